// File: rtl/pwm_bank.sv
// Bank of NCH PWM channels sharing one prescaler and one period counter, with a
// double-buffered config (pending -> active at wrap); outputs lag cnt by one clock, no backpressure.
module pwm_bank #(
    parameter int               NCH        = 4,
    parameter int               CNT_W      = 16,
    parameter int               PRE_W      = 8,
    parameter logic [CNT_W-1:0] PERIOD_RST = 16'hFFFF
) (
    input  logic                 axi_aclk,
    input  logic                 axi_areset,
    input  logic                 en,
    input  logic [PRE_W-1:0]     cfg_prescale,
    input  logic [CNT_W-1:0]     cfg_period,
    input  logic [NCH*CNT_W-1:0] cfg_duty,
    input  logic [NCH*2-1:0]     cfg_mode,
    input  logic                 cfg_load,
    output logic                 cfg_pending,
    output logic [NCH-1:0]       pwm_out,
    output logic                 wrap_pulse,
    output logic [CNT_W-1:0]     cnt_out
);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_PWM   = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    logic [PRE_W-1:0]     pre_cnt;
    logic [CNT_W-1:0]     cnt;
    logic                 tick;
    logic                 wrap;

    logic [CNT_W-1:0]     period_act;
    logic [NCH*CNT_W-1:0] duty_act;
    logic [NCH*2-1:0]     mode_act;
    logic [CNT_W-1:0]     period_pend;
    logic [NCH*CNT_W-1:0] duty_pend;
    logic [NCH*2-1:0]     mode_pend;
    logic                 pending_q;

    logic [NCH-1:0]       blink_q;
    logic [NCH-1:0]       level_nxt;

    function automatic logic chan_level(
        input logic [1:0]       mode,
        input logic [CNT_W-1:0] duty,
        input logic [CNT_W-1:0] count,
        input logic [CNT_W-1:0] period,
        input logic             blink
    );
        logic lvl;
        lvl = 1'b0;
        case (mode)
            MODE_OFF:   lvl = 1'b0;
            MODE_ON:    lvl = 1'b1;
            // duty above the period pins the output high even while cnt runs past period
            MODE_PWM:   lvl = (duty > period) || (count < duty);
            MODE_BLINK: lvl = blink;
            default:    lvl = 1'b0;
        endcase
        return lvl;
    endfunction

    assign tick = en && (pre_cnt == cfg_prescale);
    assign wrap = tick && (cnt == period_act);

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            pre_cnt    <= '0;
            cnt        <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= wrap;
            if (en) begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            end
            // a shrunken period lets cnt run on through all-ones and roll over naturally
            if (tick) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            period_act  <= PERIOD_RST;
            duty_act    <= '0;
            mode_act    <= '0;
            period_pend <= '0;
            duty_pend   <= '0;
            mode_pend   <= '0;
            pending_q   <= 1'b0;
        end else begin
            if (wrap && pending_q) begin
                period_act <= period_pend;
                duty_act   <= duty_pend;
                mode_act   <= mode_pend;
            end
            // a load on the wrap cycle still reads the old pending set above
            if (cfg_load) begin
                period_pend <= cfg_period;
                duty_pend   <= cfg_duty;
                mode_pend   <= cfg_mode;
                pending_q   <= 1'b1;
            end else if (wrap && pending_q) begin
                pending_q <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign level_nxt[i] = chan_level(mode_act[i*2 +: 2], duty_act[i*CNT_W +: CNT_W],
                                         cnt, period_act, blink_q[i]);
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            blink_q <= '0;
            pwm_out <= '0;
        end else if (en) begin
            pwm_out <= level_nxt;
            for (int i = 0; i < NCH; i++) begin
                if (mode_act[i*2 +: 2] != MODE_BLINK) begin
                    blink_q[i] <= 1'b0;
                end else if (wrap) begin
                    blink_q[i] <= ~blink_q[i];
                end
            end
        end
    end

    assign cfg_pending = pending_q;
    assign cnt_out     = cnt;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: per-clock expectations queued from period descriptions and popped each clock.
module tb_pwm_bank;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_PWM   = 2'd2;
    localparam logic [1:0] M_BLINK = 2'd3;

    logic        clk = 1'b0;
    logic        axi_areset;
    logic        en;
    logic [7:0]  cfg_prescale;
    logic [7:0]  cfg_period;
    logic [31:0] cfg_duty;
    logic [7:0]  cfg_mode;
    logic        cfg_load;
    logic        cfg_pending;
    logic [3:0]  pwm_out;
    logic        wrap_pulse;
    logic [7:0]  cnt_out;

    always #5 clk = ~clk;

    pwm_bank #(
        .NCH        (4),
        .CNT_W      (8),
        .PRE_W      (8),
        .PERIOD_RST (8'hFF)
    ) dut (
        .axi_aclk     (clk),
        .axi_areset   (axi_areset),
        .en           (en),
        .cfg_prescale (cfg_prescale),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_mode     (cfg_mode),
        .cfg_load     (cfg_load),
        .cfg_pending  (cfg_pending),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .cnt_out      (cnt_out)
    );

    typedef struct {
        logic [3:0] pwm;
        logic       wrap;
        logic [7:0] cnt;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "reset";
    int    c;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, name, got, want);
        end
    endtask

    // One period of T ticks at P clocks per tick, starting just after a wrap sample.
    // Channel i is high for the first h_i ticks; frz_n duplicates of sample frz_k model en low.
    task automatic push_period(input int t, input int p, input int h0, input int h1,
                               input int h2, input int h3, input int frz_k, input int frz_n);
        exp_t e;
        int   h[4];
        h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
        for (int k = 1; k <= t * p; k++) begin
            e.cnt  = 8'((k / p) % t);
            e.wrap = (k == t * p);
            for (int i = 0; i < 4; i++) e.pwm[i] = (((k - 1) / p) < h[i]);
            sb.push_back(e);
            if (k == frz_k) begin
                for (int j = 0; j < frz_n; j++) sb.push_back(e);
            end
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pwm_out", 32'(pwm_out), 32'(e.pwm));
            chk("wrap_pulse", 32'(wrap_pulse), 32'(e.wrap));
            chk("cnt_out", 32'(cnt_out), 32'(e.cnt));
        end
    endtask

    task automatic load_step(input logic [7:0] per, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3, input logic [1:0] m0,
                             input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] m3);
        cfg_period = per;
        cfg_duty   = {d3, d2, d1, d0};
        cfg_mode   = {m3, m2, m1, m0};
        cfg_load   = 1'b1;
        step();
        cfg_load   = 1'b0;
    endtask

    initial begin
        axi_areset   = 1'b1;
        en           = 1'b0;
        cfg_load     = 1'b0;
        cfg_prescale = 8'd0;
        cfg_period   = 8'd0;
        cfg_duty     = 32'd0;
        cfg_mode     = 8'd0;
        step();
        step();
        chk("pwm_out", 32'(pwm_out), 32'd0);
        chk("wrap_pulse", 32'(wrap_pulse), 32'd0);
        chk("cfg_pending", 32'(cfg_pending), 32'd0);
        chk("cnt_out", 32'(cnt_out), 32'd0);

        // first wrap after reset takes PERIOD_RST+1 ticks and applies the loaded set
        phase      = "first_wrap";
        axi_areset = 1'b0;
        en         = 1'b1;
        load_step(8'd9, 8'd3, 8'd0, 8'd0, 8'd0, M_PWM, M_OFF, M_OFF, M_OFF);
        chk("cfg_pending", 32'(cfg_pending), 32'd1);
        c = 1;
        while (wrap_pulse !== 1'b1 && c < 400) begin
            step();
            c++;
        end
        chk("wrap_delay", 32'(c), 32'd256);
        chk("cfg_pending", 32'(cfg_pending), 32'd0);
        chk("cnt_out", 32'(cnt_out), 32'd0);

        // duty 3 of 10; second period carries an overwritten double load
        phase = "pwm_basic";
        push_period(10, 1, 3, 0, 0, 0, 0, 0);
        push_period(10, 1, 3, 0, 0, 0, 0, 0);
        repeat (12) step();
        load_step(8'd9, 8'd7, 8'd7, 8'd7, 8'd7, M_ON, M_ON, M_ON, M_ON);
        chk("cfg_pending", 32'(cfg_pending), 32'd1);
        step();
        load_step(8'd9, 8'd0, 8'd9, 8'd10, 8'd200, M_PWM, M_PWM, M_PWM, M_PWM);
        repeat (5) step();
        chk("cfg_pending", 32'(cfg_pending), 32'd0);

        // duty edges 0/9/10/200, then a load landing exactly on the wrap edge
        phase = "duty_edges";
        push_period(10, 1, 0, 9, 10, 10, 0, 0);
        push_period(10, 1, 3, 9, 10, 10, 0, 0);
        push_period(10, 1, 5, 9, 10, 10, 0, 0);
        repeat (2) step();
        load_step(8'd9, 8'd3, 8'd9, 8'd10, 8'd200, M_PWM, M_PWM, M_PWM, M_PWM);
        chk("cfg_pending", 32'(cfg_pending), 32'd1);
        repeat (6) step();
        load_step(8'd9, 8'd5, 8'd9, 8'd10, 8'd200, M_PWM, M_PWM, M_PWM, M_PWM);
        chk("pending_on_wrap", 32'(cfg_pending), 32'd1);
        repeat (5) step();
        chk("pending_mid", 32'(cfg_pending), 32'd1);
        repeat (5) step();
        chk("pending_second_wrap", 32'(cfg_pending), 32'd0);
        repeat (3) step();
        load_step(8'd4, 8'd2, 8'd0, 8'd0, 8'd0, M_PWM, M_OFF, M_OFF, M_OFF);
        repeat (6) step();

        // prescale 3 with period 4: 20-clock wraps, cnt steps every 4 clocks
        phase        = "prescale";
        cfg_prescale = 8'd3;
        push_period(5, 4, 2, 0, 0, 0, 0, 0);
        push_period(5, 4, 2, 0, 0, 0, 0, 0);
        repeat (25) step();
        load_step(8'd9, 8'd0, 8'd0, 8'd0, 8'd0, M_OFF, M_BLINK, M_OFF, M_OFF);
        repeat (14) step();
        cfg_prescale = 8'd0;

        // blink on channel 1; en low for 7 clocks stretches one period to 17
        phase = "blink";
        push_period(10, 1, 0, 0, 0, 0, 0, 0);
        push_period(10, 1, 0, 10, 0, 0, 5, 7);
        push_period(10, 1, 10, 0, 0, 0, 0, 0);
        repeat (10) step();
        repeat (5) step();
        en = 1'b0;
        repeat (3) step();
        load_step(8'd9, 8'd0, 8'd0, 8'd0, 8'd0, M_ON, M_BLINK, M_OFF, M_OFF);
        chk("pending_while_idle", 32'(cfg_pending), 32'd1);
        repeat (3) step();
        en = 1'b1;
        repeat (5) step();
        chk("cfg_pending", 32'(cfg_pending), 32'd0);
        repeat (10) step();

        // reset mid-period with a pending set and a coincident load
        phase = "reset_mid";
        repeat (2) step();
        load_step(8'd9, 8'd1, 8'd1, 8'd1, 8'd1, M_PWM, M_PWM, M_PWM, M_PWM);
        chk("cfg_pending", 32'(cfg_pending), 32'd1);
        axi_areset = 1'b1;
        cfg_load   = 1'b1;
        step();
        axi_areset = 1'b0;
        cfg_load   = 1'b0;
        chk("pwm_out", 32'(pwm_out), 32'd0);
        chk("wrap_pulse", 32'(wrap_pulse), 32'd0);
        chk("cfg_pending", 32'(cfg_pending), 32'd0);
        chk("cnt_out", 32'(cnt_out), 32'd0);
        c = 0;
        while (wrap_pulse !== 1'b1 && c < 400) begin
            step();
            c++;
        end
        chk("wrap_delay", 32'(c), 32'd256);
        chk("pwm_out", 32'(pwm_out), 32'd0);
        chk("cfg_pending", 32'(cfg_pending), 32'd0);

        phase = "end";
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
